// File: rtl/onehot_decoder_seq.sv
// rtl/onehot_decoder_seq.sv - sequential one-hot strobe decoder with hold/gap timing and one-entry pending buffer
//
// Ports:
//   clk            rising-edge clock
//   rst_n          asynchronous active-low reset
//   in_valid       upstream transaction valid
//   in_ready       block can accept a transaction this cycle (= !pending full)
//   in_code        encoded index, sampled on acceptance
//   in_valid_data  encoder "any request" flag, sampled on acceptance
//   Data           registered one-hot (or all-zero) strobe
//   data_valid     high during HOLD cycles
//   none_flag      high during HOLD of a transaction with in_valid_data=0
//   busy           state != IDLE or pending buffer full
module onehot_decoder_seq #(
    parameter int CODE_W = 3,
    parameter int HOLD   = 2,
    parameter int GAP    = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [CODE_W-1:0]        in_code,
    input  logic                     in_valid_data,
    output logic [(2**CODE_W)-1:0]   Data,
    output logic                     data_valid,
    output logic                     none_flag,
    output logic                     busy
);

    localparam int DATA_W = 2**CODE_W;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_HOLD = 2'd1;
    localparam logic [1:0] S_GAP  = 2'd2;

    // Reload values; GAP_LD is unused when GAP is 0 and wraps harmlessly.
    localparam logic [3:0] HOLD_LD = 4'(HOLD - 1);
    localparam logic [3:0] GAP_LD  = 4'(GAP - 1);

    logic [1:0]        state;
    logic [3:0]        cnt;
    logic              pend_full;
    logic [CODE_W-1:0] pend_code;
    logic              pend_vd;

    logic              accept;
    logic              slot_end;
    logic              use_pend;
    logic              take_new;
    logic              write_pend;
    logic              load_out;
    logic [CODE_W-1:0] load_code;
    logic              load_vd;

    function automatic logic [DATA_W-1:0] decode(input logic [CODE_W-1:0] c, input logic v);
        decode = '0;
        if (v) begin
            decode[c] = 1'b1;
        end
    endfunction

    assign in_ready = !pend_full;
    assign busy     = (state != S_IDLE) || pend_full;
    assign accept   = in_valid && in_ready;

    always_comb begin
        // The last cycle of a slot: end of GAP, or end of HOLD when there is no gap.
        slot_end   = ((state == S_HOLD) && (cnt == 4'd0) && (GAP == 0)) ||
                     ((state == S_GAP)  && (cnt == 4'd0));
        use_pend   = slot_end && pend_full;
        // A new transaction goes straight to the output only when nothing older is waiting.
        take_new   = accept && ((state == S_IDLE) || (slot_end && !pend_full));
        write_pend = accept && !take_new;
        load_out   = use_pend || take_new;
        load_code  = use_pend ? pend_code : in_code;
        load_vd    = use_pend ? pend_vd   : in_valid_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            cnt        <= 4'd0;
            Data       <= '0;
            data_valid <= 1'b0;
            none_flag  <= 1'b0;
        end else if (load_out) begin
            Data       <= decode(load_code, load_vd);
            none_flag  <= !load_vd;
            data_valid <= 1'b1;
            cnt        <= HOLD_LD;
            state      <= S_HOLD;
        end else begin
            case (state)
                S_HOLD: begin
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else if (GAP > 0) begin
                        Data       <= '0;
                        data_valid <= 1'b0;
                        none_flag  <= 1'b0;
                        cnt        <= GAP_LD;
                        state      <= S_GAP;
                    end else begin
                        Data       <= '0;
                        data_valid <= 1'b0;
                        none_flag  <= 1'b0;
                        state      <= S_IDLE;
                    end
                end
                S_GAP: begin
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        state <= S_IDLE;
                    end
                end
                S_IDLE: begin
                end
                default: begin
                    Data       <= '0;
                    data_valid <= 1'b0;
                    none_flag  <= 1'b0;
                    cnt        <= 4'd0;
                    state      <= S_IDLE;
                end
            endcase
        end
    end

    // Pending slot: a simultaneous drain and refill at end of slot leaves it full.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_full <= 1'b0;
            pend_code <= '0;
            pend_vd   <= 1'b0;
        end else if (write_pend) begin
            pend_full <= 1'b1;
            pend_code <= in_code;
            pend_vd   <= in_valid_data;
        end else if (use_pend) begin
            pend_full <= 1'b0;
        end
    end

endmodule

// File: tb/tb_onehot_decoder_seq.sv
// tb/tb_onehot_decoder_seq.sv - directed self-checking bench for onehot_decoder_seq
module tb_onehot_decoder_seq;

    logic       clk;
    logic       rst_n;

    logic       a_valid, a_ready, a_vd, a_dv, a_none, a_busy;
    logic [2:0] a_code;
    logic [7:0] a_data;

    logic       b_valid, b_ready, b_vd, b_dv, b_none, b_busy;
    logic [2:0] b_code;
    logic [7:0] b_data;

    int checks = 0;
    int errors = 0;

    onehot_decoder_seq #(.CODE_W(3), .HOLD(2), .GAP(1)) dut_a (
        .clk(clk), .rst_n(rst_n),
        .in_valid(a_valid), .in_ready(a_ready),
        .in_code(a_code), .in_valid_data(a_vd),
        .Data(a_data), .data_valid(a_dv), .none_flag(a_none), .busy(a_busy)
    );

    onehot_decoder_seq #(.CODE_W(3), .HOLD(1), .GAP(0)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .in_valid(b_valid), .in_ready(b_ready),
        .in_code(b_code), .in_valid_data(b_vd),
        .Data(b_data), .data_valid(b_dv), .none_flag(b_none), .busy(b_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_a(input string tag, input logic [7:0] d, input logic dv,
                           input logic nf, input logic bz);
        check({tag, ".data"}, 32'(a_data), 32'(d));
        check({tag, ".dv"},   32'(a_dv),   32'(dv));
        check({tag, ".none"}, 32'(a_none), 32'(nf));
        check({tag, ".busy"}, 32'(a_busy), 32'(bz));
    endtask

    logic [7:0] exp_b;

    initial begin
        rst_n   = 1'b1;
        a_valid = 1'b0; a_code = 3'd0; a_vd = 1'b0;
        b_valid = 1'b0; b_code = 3'd0; b_vd = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check_a("reset", 8'h00, 1'b0, 1'b0, 1'b0);
        check("reset.ready", 32'(a_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;

        // Single transaction, code 5
        a_valid = 1'b1; a_code = 3'd5; a_vd = 1'b1;
        tick();
        a_valid = 1'b0; a_code = 3'd1; a_vd = 1'b0;
        check_a("t1.c1", 8'h20, 1'b1, 1'b0, 1'b1);
        tick(); check_a("t1.c2", 8'h20, 1'b1, 1'b0, 1'b1);
        tick(); check_a("t1.c3", 8'h00, 1'b0, 1'b0, 1'b1);
        tick(); check_a("t1.c4", 8'h00, 1'b0, 1'b0, 1'b0);

        // No-data transaction
        a_valid = 1'b1; a_code = 3'd3; a_vd = 1'b0;
        tick();
        a_valid = 1'b0;
        check_a("t2.c1", 8'h00, 1'b1, 1'b1, 1'b1);
        tick(); check_a("t2.c2", 8'h00, 1'b1, 1'b1, 1'b1);
        tick(); check_a("t2.c3", 8'h00, 1'b0, 1'b0, 1'b1);
        tick(); check_a("t2.c4", 8'h00, 1'b0, 1'b0, 1'b0);

        // Back-to-back 7, 0, 2
        a_valid = 1'b1; a_code = 3'd7; a_vd = 1'b1;
        tick(); check("t3.e0", 32'(a_data), 32'h80);
        a_code = 3'd0;
        tick(); check("t3.e1", 32'(a_data), 32'h80);
        check("t3.ready1", 32'(a_ready), 32'd0);
        a_code = 3'd2;
        tick(); check("t3.e2", 32'(a_data), 32'h00);
        tick(); check("t3.e3", 32'(a_data), 32'h01);
        check("t3.ready3", 32'(a_ready), 32'd1);
        tick(); check("t3.e4", 32'(a_data), 32'h01);
        check("t3.ready4", 32'(a_ready), 32'd0);
        a_valid = 1'b0;
        tick(); check("t3.e5", 32'(a_data), 32'h00);
        tick(); check("t3.e6", 32'(a_data), 32'h04);
        tick(); check("t3.e7", 32'(a_data), 32'h04);
        tick(); check("t3.e8", 32'(a_data), 32'h00);
        tick(); check("t3.idle", 32'(a_busy), 32'd0);

        // End-of-slot bypass: code 6 offered only in the last GAP cycle
        a_valid = 1'b1; a_code = 3'd1; a_vd = 1'b1;
        tick(); a_valid = 1'b0;
        check("t4.e0", 32'(a_data), 32'h02);
        tick(); check("t4.e1", 32'(a_data), 32'h02);
        tick(); check("t4.e2", 32'(a_data), 32'h00);
        a_valid = 1'b1; a_code = 3'd6;
        tick(); a_valid = 1'b0;
        check_a("t4.bypass", 8'h40, 1'b1, 1'b0, 1'b1);
        tick(); check("t4.e4", 32'(a_data), 32'h40);
        tick(); check("t4.e5", 32'(a_data), 32'h00);
        tick(); check("t4.idle", 32'(a_busy), 32'd0);

        // HOLD=1 GAP=0 stream on second instance
        b_valid = 1'b1; b_vd = 1'b1;
        for (int k = 0; k < 8; k++) begin
            b_code = 3'(k);
            tick();
            exp_b = 8'b1 << k;
            check("t5.data", 32'(b_data), 32'(exp_b));
            check("t5.dv", 32'(b_dv), 32'd1);
        end
        b_valid = 1'b0;
        tick();
        check("t5.end.dv", 32'(b_dv), 32'd0);
        check("t5.end.busy", 32'(b_busy), 32'd0);

        // Async reset mid-HOLD with pending full
        a_valid = 1'b1; a_code = 3'd4; a_vd = 1'b1;
        tick(); a_code = 3'd3;
        tick(); a_valid = 1'b0;
        check("t6.pre.ready", 32'(a_ready), 32'd0);
        check("t6.pre.data", 32'(a_data), 32'h10);
        #2 rst_n = 1'b0;
        #1;
        check_a("t6.rst", 8'h00, 1'b0, 1'b0, 1'b0);
        check("t6.rst.ready", 32'(a_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            check("t6.stale", 32'(a_data), 32'h00);
        end
        a_valid = 1'b1; a_code = 3'd2; a_vd = 1'b1;
        tick(); a_valid = 1'b0;
        check_a("t6.new", 8'h04, 1'b1, 1'b0, 1'b1);
        tick(); check("t6.new2", 32'(a_data), 32'h04);
        tick(); check("t6.gap", 32'(a_data), 32'h00);
        tick(); check("t6.idle", 32'(a_busy), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
